alu_arbiter_ctrl: RTL and testbench
===================================

// Module: alu_arbiter_ctrl
// PURPOSE
//   Shares one combinational alu (32-bit, op codes ADD=4..NOT=13) between two requesters.
//   - Round-robin arbitration; operands latched and held stable on the alu inputs for the op's latency.
//   - Result captured into a response register and returned with valid/ready and a requester ID.
//   - Sits between the decode/issue stages and the shared alu instance.
// PARAMETERS
//   WIDTH_DATA     32  operand/result width; must match the alu instance
//   MULDIV_CYCLES  4   EXEC cycles granted to MUL(6)/DIV(7); legal range 1..15
// PORTS
//   clk            in   1           single clock, rising edge
//   rst_n          in   1           asynchronous, active-low reset
//   req0_valid     in   1           requester 0 has an op
//   req0_ready     out  1           requester 0 op accepted this cycle
//   req0_op_a      in   WIDTH_DATA  requester 0 operand a
//   req0_op_b      in   WIDTH_DATA  requester 0 operand b
//   req0_op_code   in   5           requester 0 op code
//   req1_*         --   --          same five ports for requester 1
//   alu_operand_a  out  WIDTH_DATA  to alu.operand_a (registered)
//   alu_operand_b  out  WIDTH_DATA  to alu.operand_b (registered)
//   alu_op_code    out  5           to alu.op_code (registered)
//   alu_result     in   WIDTH_DATA  from alu.result
//   rsp_valid      out  1           response available
//   rsp_ready      in   1           consumer takes the response
//   rsp_id         out  1           requester owning the response
//   rsp_result     out  WIDTH_DATA  captured alu result
// BEHAVIOUR
//   Reset state
//     - Async on rst_n low: state IDLE; all outputs and registers 0.
//     - last_grant=1, so req0 wins the first contention.
//   FSM states: IDLE, EXEC, RESP
//   IDLE: grant and accept
//     - Grant req0 if only req0 valid; req1 if only req1 valid.
//     - Both valid: grant the one != last_grant.
//     - reqN_ready = (state==IDLE) && grant==N; combinational, never both high.
//     - Accept when valid&&ready: latch op_a/op_b/op_code onto alu_* regs, store id, update last_grant.
//     - Set cnt = (op_code==6||7) ? MULDIV_CYCLES-1 : 0; go EXEC.
//   EXEC: wait for the op
//     - alu_* held constant. cnt decrements each cycle.
//     - At cnt==0: rsp_result<=alu_result, rsp_id<=id, rsp_valid<=1; go RESP.
//   RESP: return the response
//     - rsp_valid/rsp_id/rsp_result held stable until rsp_ready.
//     - On rsp_ready: rsp_valid<=0; go IDLE.
//     - No new accept while RESP; rsp_ready low stalls indefinitely.
//   Latency and throughput
//     - Accept at edge t: rsp_valid high from t+N+1 (N=1 simple ops, MULDIV_CYCLES for MUL/DIV).
//     - Back-to-back with rsp_ready=1: one op per N+2 cycles.
//   Boundary conditions
//     - Unknown op codes (0-3, 14-31): executed with N=1; result is whatever alu returns (0).
//     - alu_* retain last op after RESP; no zeroing between ops.
//     - reqN_valid dropping before accept: no effect, no state change.
//     - rst_n low mid-EXEC/RESP: op aborted, response lost, outputs 0 immediately.
// CONFIGURATION
//   ALU_ARB_DIVZ_ERR_EN defined
//     - Adds port rsp_err out 1.
//     - Set with rsp_valid when captured op_code==7 && alu_operand_b==0; reset 0, held like rsp_result.
//   ALU_ARB_DIVZ_ERR_EN undefined
//     - Port absent; div-by-zero returns 0 with no indication.
// TESTING
//   1 req0 ADD a=5 b=7, rsp_ready=1 -> accepted t; rsp_valid t+2, rsp_result=12, rsp_id=0.
//   2 req0,req1 both SUB 9-3 held valid, rsp_ready=1 -> grants 0,1,0,1 alternating; rsp_id alternates; results 6.
//   3 req1 MUL 6*7, MULDIV_CYCLES=4 -> rsp_valid exactly t+5, result 42; alu_* stable t+1..t+4.
//   4 req0 AND after rsp_ready=0 for 10 cycles -> rsp_valid/result held; req ready low until drain.
//   5 rst_n low during EXEC of DIV -> all outputs 0 at once; next both-valid contention grants req0.
//   6 (ALU_ARB_DIVZ_ERR_EN) DIV 8/0 -> rsp_result=0, rsp_err=1; DIV 8/2 -> 4, rsp_err=0.

Source files
------------

// File: rtl/alu_arbiter_ctrl.sv
// alu_arbiter_ctrl: shares one combinational alu between two requesters.
// Round-robin grant in IDLE, operands held on the alu for the op latency in
// EXEC, result returned through a valid/ready response register in RESP.
// Optional feature macro: ALU_ARB_DIVZ_ERR_EN adds the rsp_err output that
// flags a divide by zero alongside the response.
module alu_arbiter_ctrl #(
    parameter int WIDTH_DATA    = 32,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [WIDTH_DATA-1:0] req0_op_a,
    input  logic [WIDTH_DATA-1:0] req0_op_b,
    input  logic [4:0]            req0_op_code,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [WIDTH_DATA-1:0] req1_op_a,
    input  logic [WIDTH_DATA-1:0] req1_op_b,
    input  logic [4:0]            req1_op_code,
    output logic [WIDTH_DATA-1:0] alu_operand_a,
    output logic [WIDTH_DATA-1:0] alu_operand_b,
    output logic [4:0]            alu_op_code,
    input  logic [WIDTH_DATA-1:0] alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [WIDTH_DATA-1:0] rsp_result
`ifdef ALU_ARB_DIVZ_ERR_EN
    ,
    output logic                  rsp_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [4:0] OP_MUL     = 5'd6;
    localparam logic [4:0] OP_DIV     = 5'd7;
    // Countdown preload for multi-cycle ops; simple ops leave EXEC after one cycle.
    localparam logic [3:0] CNT_MULDIV = 4'(MULDIV_CYCLES - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  id_q, id_d;
    logic [WIDTH_DATA-1:0] alu_operand_a_q, alu_operand_a_d;
    logic [WIDTH_DATA-1:0] alu_operand_b_q, alu_operand_b_d;
    logic [4:0]            alu_op_code_q, alu_op_code_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_id_q, rsp_id_d;
    logic [WIDTH_DATA-1:0] rsp_result_q, rsp_result_d;
`ifdef ALU_ARB_DIVZ_ERR_EN
    logic                  rsp_err_q, rsp_err_d;
`endif

    logic                  grant;
    logic                  accept;
    logic [WIDTH_DATA-1:0] sel_op_a;
    logic [WIDTH_DATA-1:0] sel_op_b;
    logic [4:0]            sel_op_code;

    // Round-robin grant and the ready handshake offered in IDLE.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        req0_ready  = (state_q == IDLE) && req0_valid && !grant;
        req1_ready  = (state_q == IDLE) && req1_valid && grant;
        accept      = req0_ready || req1_ready;
        sel_op_a    = grant ? req1_op_a    : req0_op_a;
        sel_op_b    = grant ? req1_op_b    : req0_op_b;
        sel_op_code = grant ? req1_op_code : req0_op_code;
    end

    // Next-state and register-update logic for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        last_grant_d    = last_grant_q;
        id_d            = id_q;
        alu_operand_a_d = alu_operand_a_q;
        alu_operand_b_d = alu_operand_b_q;
        alu_op_code_d   = alu_op_code_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_id_d        = rsp_id_q;
        rsp_result_d    = rsp_result_q;
`ifdef ALU_ARB_DIVZ_ERR_EN
        rsp_err_d       = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_operand_a_d = sel_op_a;
                    alu_operand_b_d = sel_op_b;
                    alu_op_code_d   = sel_op_code;
                    id_d            = grant;
                    last_grant_d    = grant;
                    cnt_d           = ((sel_op_code == OP_MUL) || (sel_op_code == OP_DIV))
                                      ? CNT_MULDIV : 4'd0;
                    state_d         = EXEC;
                end
            end
            EXEC: begin
                // Operands stay on the alu inputs; capture once the countdown expires.
                if (cnt_q == 4'd0) begin
                    rsp_result_d = alu_result;
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
`ifdef ALU_ARB_DIVZ_ERR_EN
                    rsp_err_d    = (alu_op_code_q == OP_DIV) && (alu_operand_b_q == '0);
`endif
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Response held until the consumer takes it; no new grant meanwhile.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything except last_grant=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= 4'd0;
            last_grant_q    <= 1'b1;
            id_q            <= 1'b0;
            alu_operand_a_q <= '0;
            alu_operand_b_q <= '0;
            alu_op_code_q   <= 5'd0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= 1'b0;
            rsp_result_q    <= '0;
`ifdef ALU_ARB_DIVZ_ERR_EN
            rsp_err_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            last_grant_q    <= last_grant_d;
            id_q            <= id_d;
            alu_operand_a_q <= alu_operand_a_d;
            alu_operand_b_q <= alu_operand_b_d;
            alu_op_code_q   <= alu_op_code_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_id_q        <= rsp_id_d;
            rsp_result_q    <= rsp_result_d;
`ifdef ALU_ARB_DIVZ_ERR_EN
            rsp_err_q       <= rsp_err_d;
`endif
        end
    end

    assign alu_operand_a = alu_operand_a_q;
    assign alu_operand_b = alu_operand_b_q;
    assign alu_op_code   = alu_op_code_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_result    = rsp_result_q;
`ifdef ALU_ARB_DIVZ_ERR_EN
    assign rsp_err       = rsp_err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// tb_alu_arbiter_ctrl: directed bench for alu_arbiter_ctrl. The bench plays
// the shared alu, keeps a transaction-level model (accept cycle + latency)
// that is compared on every falling edge, and pins it with literal checks.
module tb_alu_arbiter_ctrl;

    localparam int W  = 32;
    localparam int MD = 4;

    localparam logic [4:0] OP_ADD = 5'd4;
    localparam logic [4:0] OP_SUB = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6;
    localparam logic [4:0] OP_DIV = 5'd7;
    localparam logic [4:0] OP_AND = 5'd8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_op_a, req0_op_b, req1_op_a, req1_op_b;
    logic [4:0]   req0_op_code, req1_op_code;
    logic [W-1:0] alu_operand_a, alu_operand_b, alu_result, rsp_result;
    logic [4:0]   alu_op_code;
    logic         rsp_valid, rsp_ready, rsp_id;
`ifdef ALU_ARB_DIVZ_ERR_EN
    logic         rsp_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    alu_arbiter_ctrl #(.WIDTH_DATA(W), .MULDIV_CYCLES(MD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op_a(req0_op_a), .req0_op_b(req0_op_b), .req0_op_code(req0_op_code),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op_a(req1_op_a), .req1_op_b(req1_op_b), .req1_op_code(req1_op_code),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_op_code(alu_op_code), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result)
`ifdef ALU_ARB_DIVZ_ERR_EN
        , .rsp_err(rsp_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference alu behaviour; unknown codes and divide by zero give 0.
    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [4:0] code);
        case (code)
            5'd4:    return a + b;
            5'd5:    return a - b;
            5'd6:    return a * b;
            5'd7:    return (b == 0) ? '0 : a / b;
            5'd8:    return a & b;
            5'd9:    return a | b;
            5'd10:   return a ^ b;
            5'd11:   return a << b[4:0];
            5'd12:   return a >> b[4:0];
            5'd13:   return ~a;
            default: return '0;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_operand_a, alu_operand_b, alu_op_code);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // ---------------- transaction-level model + per-cycle compare ----------------
    bit         m_busy;
    int         m_acc, m_lat;
    bit         m_id, m_last;
    logic [W-1:0] m_a, m_b;
    logic [4:0] m_code;

    initial begin
        m_busy = 0; m_acc = 0; m_lat = 1; m_id = 0; m_last = 1;
        m_a = '0; m_b = '0; m_code = '0;
    end

    always @(negedge clk) begin
        bit exp_valid, exp_r0, exp_r1;
        if (!rst_n) begin
            m_busy = 0; m_last = 1; m_id = 0;
            m_a = '0; m_b = '0; m_code = '0;
        end
        exp_valid = m_busy && (cyc >= m_acc + m_lat + 1);
        exp_r0 = !m_busy && req0_valid && (!req1_valid || m_last);
        exp_r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
        check("m_req0_ready", req0_ready, exp_r0);
        check("m_req1_ready", req1_ready, exp_r1);
        check("m_rsp_valid", rsp_valid, exp_valid);
        check("m_alu_a", alu_operand_a, m_a);
        check("m_alu_b", alu_operand_b, m_b);
        check("m_alu_code", alu_op_code, m_code);
        if (!rst_n) begin
            check("m_rst_rsp_result", rsp_result, 0);
            check("m_rst_rsp_id", rsp_id, 0);
        end
        if (exp_valid) begin
            check("m_rsp_id", rsp_id, m_id);
            check("m_rsp_result", rsp_result, alu_fn(m_a, m_b, m_code));
`ifdef ALU_ARB_DIVZ_ERR_EN
            check("m_rsp_err", rsp_err, (m_code == OP_DIV) && (m_b == 0));
`endif
        end
        if (rst_n) begin
            if (exp_r0 || exp_r1) begin
                m_id   = exp_r1;
                m_last = exp_r1;
                m_a    = exp_r1 ? req1_op_a : req0_op_a;
                m_b    = exp_r1 ? req1_op_b : req0_op_b;
                m_code = exp_r1 ? req1_op_code : req0_op_code;
                m_lat  = (m_code == OP_MUL || m_code == OP_DIV) ? MD : 1;
                m_acc  = cyc;
                m_busy = 1;
            end else if (exp_valid && rsp_ready) begin
                m_busy = 0;
            end
        end
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic set_req(input int r, input bit v, input logic [4:0] code,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (r == 0) begin
            req0_valid = v; req0_op_code = code; req0_op_a = a; req0_op_b = b;
        end else begin
            req1_valid = v; req1_op_code = code; req1_op_a = a; req1_op_b = b;
        end
    endtask

    task automatic wait_accept(input int r, output int acc_c);
        acc_c = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((r == 0) ? (req0_ready && req0_valid) : (req1_ready && req1_valid)) begin
                acc_c = cyc;
                break;
            end
        end
        if (acc_c < 0) timeout_fail("accept");
    endtask

    task automatic wait_rsp(output int rsp_c);
        rsp_c = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rsp_c = cyc;
                break;
            end
        end
        if (rsp_c < 0) timeout_fail("response");
    endtask

    // One op from one requester: returns accept->response distance, result and id.
    task automatic do_single(input int r, input logic [4:0] code, input logic [W-1:0] a,
                             input logic [W-1:0] b, output int delta,
                             output logic [W-1:0] res, output logic id);
        int acc_c, rsp_c;
        @(posedge clk); #1;
        set_req(r, 1'b1, code, a, b);
        wait_accept(r, acc_c);
        @(posedge clk); #1;
        set_req(r, 1'b0, code, a, b);
        wait_rsp(rsp_c);
        delta = rsp_c - acc_c;
        res   = rsp_result;
        id    = rsp_id;
    endtask

    initial begin
        int           delta;
        logic [W-1:0] res;
        logic         id;
        int           grants[4];
        int           gcyc[4];
        int           ng;
        int           acc_c, rsp_c;

        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_alu_a", alu_operand_a, 0);

        // Contention: both hold SUB 9-3; grants alternate starting with req0.
        @(posedge clk); #1;
        set_req(0, 1'b1, OP_SUB, 9, 3);
        set_req(1, 1'b1, OP_SUB, 9, 3);
        ng = 0;
        for (int i = 0; i < 100 && ng < 4; i++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) check("both_ready", 1, 0);
            if (req0_ready || req1_ready) begin
                grants[ng] = req1_ready ? 1 : 0;
                gcyc[ng]   = cyc;
                ng++;
            end
        end
        if (ng < 4) timeout_fail("contention grants");
        @(posedge clk); #1;
        set_req(0, 1'b0, OP_SUB, 9, 3);
        set_req(1, 1'b0, OP_SUB, 9, 3);
        if (ng == 4) begin
            for (int k = 0; k < 4; k++) check($sformatf("grant_%0d", k), grants[k], k % 2);
            for (int k = 1; k < 4; k++) check($sformatf("grant_period_%0d", k), gcyc[k] - gcyc[k-1], 3);
        end
        wait_rsp(rsp_c);
        check("sub_result", rsp_result, 6);
        check("sub_last_id", rsp_id, 1);

        // Single ADD from req0.
        do_single(0, OP_ADD, 5, 7, delta, res, id);
        check("add_latency", delta, 2);
        check("add_result", res, 12);
        check("add_id", id, 0);

        // Unknown op code behaves as a one-cycle op returning 0.
        do_single(1, 5'd2, 3, 4, delta, res, id);
        check("unk_latency", delta, 2);
        check("unk_result", res, 0);
        check("unk_id", id, 1);

        // MUL from req1 uses MULDIV_CYCLES.
        do_single(1, OP_MUL, 6, 7, delta, res, id);
        check("mul_latency", delta, 5);
        check("mul_result", res, 42);
        check("mul_id", id, 1);
        check("mul_alu_a_held", alu_operand_a, 6);

        // Stalled response: held for 10 cycles while req1 waits.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        do_single(0, OP_AND, 32'hF0F0, 32'hFF00, delta, res, id);
        check("and_latency", delta, 2);
        check("and_result", res, 32'hF000);
        @(posedge clk); #1;
        set_req(1, 1'b1, OP_ADD, 1, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1);
            check("stall_result", rsp_result, 32'hF000);
            check("stall_req1_ready", req1_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_accept(1, acc_c);
        @(posedge clk); #1;
        set_req(1, 1'b0, OP_ADD, 1, 1);
        wait_rsp(rsp_c);
        check("drain_result", rsp_result, 2);
        check("drain_id", rsp_id, 1);

        // Reset in the middle of a DIV.
        @(posedge clk); #1;
        set_req(0, 1'b1, OP_DIV, 100, 5);
        wait_accept(0, acc_c);
        @(posedge clk); #1;
        set_req(0, 1'b0, OP_DIV, 100, 5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_alu_a", alu_operand_a, 0);
        check("rst_alu_code", alu_op_code, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(0, 1'b1, OP_ADD, 1, 2);
        set_req(1, 1'b1, OP_ADD, 1, 2);
        @(negedge clk);
        check("post_rst_req0_ready", req0_ready, 1);
        check("post_rst_req1_ready", req1_ready, 0);
        @(posedge clk); #1;
        set_req(0, 1'b0, OP_ADD, 1, 2);
        set_req(1, 1'b0, OP_ADD, 1, 2);
        wait_rsp(rsp_c);
        check("post_rst_result", rsp_result, 3);
        check("post_rst_id", rsp_id, 0);

`ifdef ALU_ARB_DIVZ_ERR_EN
        do_single(0, OP_DIV, 8, 0, delta, res, id);
        check("divz_result", res, 0);
        check("divz_err", rsp_err, 1);
        do_single(0, OP_DIV, 8, 2, delta, res, id);
        check("div_latency", delta, 5);
        check("div_result", res, 4);
        check("div_err", rsp_err, 0);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
